io_port_controller: RTL and testbench
=====================================

# io_port_controller

Memory-mapped I/O port block on the CPU data bus, sharing the address decode space with the 1024×8 data memory. It owns the two reserved addresses the data memory ignores: 10'h3FE (input port) and 10'h3FF (output port / status). Each direction is buffered by a small FIFO with valid/ready handshakes to external logic. Read data is returned on the shared tri-state data bus with the same registered timing as the data memory.

## Interface
- DEPTH, 4: entries per FIFO; power of two, ≥2.
- IN_PORT_ADDR, 10'h3FE: input port address.
- OUT_PORT_ADDR, 10'h3FF: output port / status address.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_addr  in  10  CPU bus address.
- in_write_en  in  1  CPU write strobe.
- in_read_en  in  1  CPU read strobe.
- in_data  in  8  CPU write data.
- out_data  out  8  CPU read data; tri-stated ('bz) unless selected.
- ext_in_valid  in  1  external producer has a byte.
- ext_in_data  in  8  external producer byte.
- ext_in_ready  out  1  input FIFO accepts a byte.
- ext_out_valid  out  1  output FIFO has a byte.
- ext_out_data  out  8  head of output FIFO.
- ext_out_ready  in  1  external consumer takes the byte.

## Operation
- Input FIFO: push when ext_in_valid && ext_in_ready; ext_in_ready = !in_full, forced 0 while rst_n low.
- Output FIFO: pop when ext_out_valid && ext_out_ready; ext_out_valid = !out_empty; ext_out_data = head entry (don't-care when empty).
- CPU read of IN_PORT_ADDR: on the first rising edge of a contiguous read access (in_read_en high and address matching, tracked by an rd_active flag), read_data <= input FIFO head and pop once. Holding in_read_en on the same address for further cycles keeps read_data and does not pop again. A new access needs in_read_en to drop or the address to change.
- Read of an empty input FIFO: read_data <= 8'h00, no pop, sticky in_underrun set.
- CPU write to OUT_PORT_ADDR: push in_data into the output FIFO on each cycle in_write_en is high. If full: data dropped, sticky out_overflow set.
- Write to IN_PORT_ADDR: ignored. Read and write asserted together on a port address: both take effect as above.
- out_data = read_data when in_read_en && address ∈ {IN_PORT_ADDR, OUT_PORT_ADDR (see Configuration)}, else 'bz.
- Counters: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits. Simultaneous push and pop on a non-empty, non-full FIFO keeps occupancy unchanged. Simultaneous pop (CPU read) and push on an empty input FIFO returns 8'h00 and sets underrun; the pushed byte stays stored.

## Timing
- Reset (async assert, sync release) state: all pointers and occupancies 0, read_data 8'h00, rd_active 0, sticky bits 0, ext_out_valid 0, ext_in_ready 0 while rst_n low then 1.
- Read latency matches the data memory: read_data updates on the edge that samples the access and is visible on out_data in the same bus cycle after that edge.
- ext_in_ready deasserts in the cycle after the push that fills the FIFO, because it is derived from registered occupancy. The first byte written by the CPU appears on ext_out_valid/ext_out_data one cycle after the write edge.
- Reset mid-transfer discards both FIFO contents and sticky bits. No partial byte survives.

## Configuration
- IO_PORT_STATUS_EN defined: a CPU read of OUT_PORT_ADDR latches the status byte {4'b0, out_overflow, in_underrun, out_full, !in_empty} into read_data and clears both sticky bits on that same edge. The clear uses first-cycle-of-access semantics, like the input read. A sticky event on the same edge wins over the clear.
- IO_PORT_STATUS_EN undefined: reads of OUT_PORT_ADDR are ignored and out_data stays 'bz. Sticky bits still exist internally but are unobservable.

## Test plan
- After reset, push 8'hA5 and 8'h3C from the external side; CPU reads 10'h3FE twice -> out_data 8'hA5 then 8'h3C, input FIFO empty afterwards.
- Hold in_read_en on 10'h3FE for 3 cycles with 2 bytes queued -> exactly one pop, out_data stable at the first byte.
- Push 4 bytes externally -> ext_in_ready 0. CPU read -> ext_in_ready returns to 1 the next cycle.
- CPU writes 8'h11..8'h15 to 10'h3FF with ext_out_ready 0 -> first 4 bytes held, 8'h15 dropped. Status read (with IO_PORT_STATUS_EN) -> 8'h0A, and a second status read -> 8'h02.
- CPU read of 10'h3FE when empty -> out_data 8'h00 and status bit2 set. Read of address 10'h010 -> out_data 'bz.
- Assert rst_n low with 3 bytes in each FIFO -> ext_out_valid 0 immediately. After release, both FIFOs are empty and a status read returns 8'h00.

Source files
------------

// File: rtl/io_port_controller.sv
// io_port_controller: CPU-mapped byte ports at IN_PORT_ADDR/OUT_PORT_ADDR, each buffered by a DEPTH-entry FIFO.
// Optional macro IO_PORT_STATUS_EN makes OUT_PORT_ADDR readable as a status byte that clears the sticky error bits.
module io_port_controller #(
  parameter int         DEPTH         = 4,
  parameter logic [9:0] IN_PORT_ADDR  = 10'h3FE,
  parameter logic [9:0] OUT_PORT_ADDR = 10'h3FF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] in_addr,
  input  logic       in_write_en,
  input  logic       in_read_en,
  input  logic [7:0] in_data,
  output logic [7:0] out_data,
  input  logic       ext_in_valid,
  input  logic [7:0] ext_in_data,
  output logic       ext_in_ready,
  output logic       ext_out_valid,
  output logic [7:0] ext_out_data,
  input  logic       ext_out_ready
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    inMem_q [DEPTH];
  logic [7:0]    outMem_q [DEPTH];

  logic [AW-1:0] inWrPtr_q, inWrPtr_d;
  logic [AW-1:0] inRdPtr_q, inRdPtr_d;
  logic [AW:0]   inCount_q, inCount_d;
  logic [AW-1:0] outWrPtr_q, outWrPtr_d;
  logic [AW-1:0] outRdPtr_q, outRdPtr_d;
  logic [AW:0]   outCount_q, outCount_d;

  logic [7:0]    readData_q, readData_d;
  logic          rdActive_q, rdActive_d;
  logic [9:0]    rdAddr_q, rdAddr_d;
  logic          inUnderrun_q, inUnderrun_d;
  logic          outOverflow_q, outOverflow_d;

  logic inSel, outSel, accessFirst;
  logic inEmpty, inFull, outEmpty, outFull;
  logic inPush, inPop, inReadFirst, underrunSet;
  logic outWrite, outPush, outPop, overflowSet;
  logic statusRead, readSel;
  logic [7:0] statusByte;

  assign inSel  = (in_addr == IN_PORT_ADDR);
  assign outSel = (in_addr == OUT_PORT_ADDR);

  // A read access lasts while in_read_en stays high on one address; only its first edge has side effects.
  assign accessFirst = in_read_en && (inSel || outSel) &&
                       !(rdActive_q && (rdAddr_q == in_addr));

  assign inEmpty  = (inCount_q == '0);
  assign inFull   = (inCount_q == FULL_COUNT);
  assign outEmpty = (outCount_q == '0);
  assign outFull  = (outCount_q == FULL_COUNT);

  assign ext_in_ready  = rst_n && !inFull;
  assign ext_out_valid = !outEmpty;
  assign ext_out_data  = outMem_q[outRdPtr_q];

  assign inPush      = ext_in_valid && ext_in_ready;
  assign inReadFirst = accessFirst && inSel;
  assign inPop       = inReadFirst && !inEmpty;
  assign underrunSet = inReadFirst && inEmpty;

  assign outWrite    = in_write_en && outSel;
  assign outPush     = outWrite && !outFull;
  assign overflowSet = outWrite && outFull;
  assign outPop      = ext_out_valid && ext_out_ready;

  assign statusByte = {4'b0000, outOverflow_q, inUnderrun_q, outFull, !inEmpty};

`ifdef IO_PORT_STATUS_EN
  assign statusRead = accessFirst && outSel;
  assign readSel    = in_read_en && (inSel || outSel);
`else
  assign statusRead = 1'b0;
  assign readSel    = in_read_en && inSel;
`endif

  assign out_data = readSel ? readData_q : 8'bzzzz_zzzz;

  always_comb begin
    inWrPtr_d  = inPush  ? inWrPtr_q  + AW'(1) : inWrPtr_q;
    inRdPtr_d  = inPop   ? inRdPtr_q  + AW'(1) : inRdPtr_q;
    inCount_d  = inCount_q + (AW + 1)'(inPush) - (AW + 1)'(inPop);
    outWrPtr_d = outPush ? outWrPtr_q + AW'(1) : outWrPtr_q;
    outRdPtr_d = outPop  ? outRdPtr_q + AW'(1) : outRdPtr_q;
    outCount_d = outCount_q + (AW + 1)'(outPush) - (AW + 1)'(outPop);
  end

  // A sticky event landing on the same edge as a status read survives the clear.
  always_comb begin
    readData_d = readData_q;
    if (inReadFirst) begin
      readData_d = inEmpty ? 8'h00 : inMem_q[inRdPtr_q];
    end else if (statusRead) begin
      readData_d = statusByte;
    end
    inUnderrun_d  = (inUnderrun_q  && !statusRead) || underrunSet;
    outOverflow_d = (outOverflow_q && !statusRead) || overflowSet;
    rdActive_d    = in_read_en && (inSel || outSel);
    rdAddr_d      = in_addr;
  end

  always_ff @(posedge clk) begin
    if (inPush) begin
      inMem_q[inWrPtr_q] <= ext_in_data;
    end
    if (outPush) begin
      outMem_q[outWrPtr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inWrPtr_q     <= '0;
      inRdPtr_q     <= '0;
      inCount_q     <= '0;
      outWrPtr_q    <= '0;
      outRdPtr_q    <= '0;
      outCount_q    <= '0;
      readData_q    <= 8'h00;
      rdActive_q    <= 1'b0;
      rdAddr_q      <= '0;
      inUnderrun_q  <= 1'b0;
      outOverflow_q <= 1'b0;
    end else begin
      inWrPtr_q     <= inWrPtr_d;
      inRdPtr_q     <= inRdPtr_d;
      inCount_q     <= inCount_d;
      outWrPtr_q    <= outWrPtr_d;
      outRdPtr_q    <= outRdPtr_d;
      outCount_q    <= outCount_d;
      readData_q    <= readData_d;
      rdActive_q    <= rdActive_d;
      rdAddr_q      <= rdAddr_d;
      inUnderrun_q  <= inUnderrun_d;
      outOverflow_q <= outOverflow_d;
    end
  end

endmodule

// File: tb/tb_io_port_controller.sv
// Self-checking bench for io_port_controller: directed scenarios plus random traffic against a queue-based model.
// Status-byte checks are compiled in only when IO_PORT_STATUS_EN is defined.
module tb_io_port_controller;

  localparam int         DEPTH      = 4;
  localparam logic [9:0] IN_ADDR    = 10'h3FE;
  localparam logic [9:0] OUT_ADDR   = 10'h3FF;
  localparam logic [9:0] OTHER_ADDR = 10'h010;
`ifdef IO_PORT_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] in_addr = OTHER_ADDR;
  logic       in_write_en = 1'b0;
  logic       in_read_en = 1'b0;
  logic [7:0] in_data = 8'h00;
  wire  [7:0] out_data;
  logic       ext_in_valid = 1'b0;
  logic [7:0] ext_in_data = 8'h00;
  logic       ext_in_ready;
  logic       ext_out_valid;
  logic [7:0] ext_out_data;
  logic       ext_out_ready = 1'b0;

  io_port_controller #(
    .DEPTH(DEPTH), .IN_PORT_ADDR(IN_ADDR), .OUT_PORT_ADDR(OUT_ADDR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_addr(in_addr), .in_write_en(in_write_en), .in_read_en(in_read_en),
    .in_data(in_data), .out_data(out_data),
    .ext_in_valid(ext_in_valid), .ext_in_data(ext_in_data), .ext_in_ready(ext_in_ready),
    .ext_out_valid(ext_out_valid), .ext_out_data(ext_out_data), .ext_out_ready(ext_out_ready)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  // Reference model: byte queues plus the CPU-visible registers.
  logic [7:0] inQ[$];
  logic [7:0] outQ[$];
  logic [7:0] mReadData;
  logic       mUnderrun, mOverflow, mPrevActive;
  logic [9:0] mPrevAddr;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %02h, expected %02h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    inQ.delete();
    outQ.delete();
    mReadData   = 8'h00;
    mUnderrun   = 1'b0;
    mOverflow   = 1'b0;
    mPrevActive = 1'b0;
    mPrevAddr   = 10'h000;
  endtask

  // Drives one bus cycle, advances the model across the edge, then checks the DUT just after the edge.
  task automatic applyStimulus(input logic inValid, input logic [7:0] inByte, input logic outReady,
                               input logic [9:0] addr, input logic rd, input logic wr,
                               input logic [7:0] wdata);
    logic isPort, firstAccess, inEmptyPre, inFullPre, outEmptyPre, outFullPre;
    logic [7:0] statusPre;
    ext_in_valid  = inValid;
    ext_in_data   = inByte;
    ext_out_ready = outReady;
    in_addr       = addr;
    in_read_en    = rd;
    in_write_en   = wr;
    in_data       = wdata;
    isPort      = (addr == IN_ADDR) || (addr == OUT_ADDR);
    firstAccess = rd && isPort && !(mPrevActive && (mPrevAddr == addr));
    inEmptyPre  = (inQ.size() == 0);
    inFullPre   = (inQ.size() == DEPTH);
    outEmptyPre = (outQ.size() == 0);
    outFullPre  = (outQ.size() == DEPTH);
    statusPre   = {4'b0000, mOverflow, mUnderrun, outFullPre, !inEmptyPre};
    @(posedge clk);
    if (firstAccess && addr == IN_ADDR) begin
      if (inEmptyPre) begin
        mReadData = 8'h00;
        mUnderrun = 1'b1;
      end else begin
        mReadData = inQ.pop_front();
      end
    end
    if (firstAccess && addr == OUT_ADDR && STATUS_EN) begin
      mReadData = statusPre;
      mUnderrun = 1'b0;
      mOverflow = 1'b0;
    end
    if (inValid && !inFullPre) inQ.push_back(inByte);
    if (outReady && !outEmptyPre) void'(outQ.pop_front());
    if (wr && addr == OUT_ADDR) begin
      if (outFullPre) mOverflow = 1'b1;
      else outQ.push_back(wdata);
    end
    mPrevActive = rd && isPort;
    mPrevAddr   = addr;
    #1;
    checkOutput("ext_in_ready", 8'(ext_in_ready), 8'(inQ.size() < DEPTH));
    checkOutput("ext_out_valid", 8'(ext_out_valid), 8'(outQ.size() != 0));
    if (outQ.size() != 0) checkOutput("ext_out_data", ext_out_data, outQ[0]);
    if (rd && (addr == IN_ADDR || (STATUS_EN && addr == OUT_ADDR)))
      checkOutput("out_data", out_data, mReadData);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, OTHER_ADDR, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pushIn(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0, OTHER_ADDR, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic readIn();
    applyStimulus(1'b0, 8'h00, 1'b0, IN_ADDR, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic readStatus();
    applyStimulus(1'b0, 8'h00, 1'b0, OUT_ADDR, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic doReset();
    ext_in_valid  = 1'b0;
    ext_out_ready = 1'b0;
    in_read_en    = 1'b0;
    in_write_en   = 1'b0;
    in_addr       = OTHER_ADDR;
    rst_n         = 1'b0;
    #1;
    checkOutput("rst_out_valid", 8'(ext_out_valid), 8'h00);
    checkOutput("rst_in_ready", 8'(ext_in_ready), 8'h00);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", 8'(ext_in_ready), 8'h01);
    checkOutput("post_rst_out_valid", 8'(ext_out_valid), 8'h00);
  endtask

  initial begin
    logic [9:0] rAddr;
    logic       rRd, rWr;
    modelReset();
    #2;
    doReset();

    // Two external bytes come back in order through separate CPU reads.
    pushIn(8'hA5);
    pushIn(8'h3C);
    readIn();
    checkOutput("t1_first", out_data, 8'hA5);
    idleCycle();
    readIn();
    checkOutput("t1_second", out_data, 8'h3C);
    idleCycle();

    // A held read pops only once and keeps the first byte on the bus.
    pushIn(8'h5A);
    pushIn(8'h6B);
    for (int i = 0; i < 3; i++) begin
      readIn();
      checkOutput("t2_hold", out_data, 8'h5A);
    end
    idleCycle();
    readIn();
    checkOutput("t2_next", out_data, 8'h6B);
    idleCycle();

    // Filling the input FIFO drops ready; one CPU read restores it.
    for (int i = 0; i < DEPTH; i++) pushIn(8'h80 + 8'(i));
    checkOutput("t3_full_ready", 8'(ext_in_ready), 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      readIn();
      checkOutput("t3_drain", out_data, 8'h80 + 8'(i));
      if (i == 0) checkOutput("t3_ready_back", 8'(ext_in_ready), 8'h01);
      idleCycle();
    end

    // Five CPU writes into a stalled output FIFO: four kept, the fifth dropped.
    checkOutput("t4_out_empty", 8'(ext_out_valid), 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, OUT_ADDR, 1'b0, 1'b1, 8'h11 + 8'(i));
      if (i == 0) begin
        checkOutput("t4_first_valid", 8'(ext_out_valid), 8'h01);
        checkOutput("t4_first_data", ext_out_data, 8'h11);
      end
    end
`ifdef IO_PORT_STATUS_EN
    readStatus();
    checkOutput("t4_status_a", out_data, 8'h0A);
    idleCycle();
    readStatus();
    checkOutput("t4_status_b", out_data, 8'h02);
    idleCycle();
`endif
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("t4_out_seq", ext_out_data, 8'h11 + 8'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, OTHER_ADDR, 1'b0, 1'b0, 8'h00);
    end
    checkOutput("t4_out_drained", 8'(ext_out_valid), 8'h00);

    // Empty read returns zero and flags underrun; a foreign address pops nothing.
    readIn();
    checkOutput("t5_empty_read", out_data, 8'h00);
    idleCycle();
`ifdef IO_PORT_STATUS_EN
    readStatus();
    checkOutput("t5_status", out_data, 8'h04);
    idleCycle();
`endif
    pushIn(8'h77);
    applyStimulus(1'b0, 8'h00, 1'b0, OTHER_ADDR, 1'b1, 1'b0, 8'h00);
    idleCycle();
    readIn();
    checkOutput("t5_no_foreign_pop", out_data, 8'h77);
    idleCycle();

    // Reset with both FIFOs partly full discards everything.
    for (int i = 0; i < 3; i++) begin
      pushIn(8'hC0 + 8'(i));
      applyStimulus(1'b0, 8'h00, 1'b0, OUT_ADDR, 1'b0, 1'b1, 8'hD0 + 8'(i));
    end
    doReset();
`ifdef IO_PORT_STATUS_EN
    readStatus();
    checkOutput("t6_status", out_data, 8'h00);
    idleCycle();
`endif
    readIn();
    checkOutput("t6_in_empty", out_data, 8'h00);
    idleCycle();

    // Random traffic; the current CPU access is often held to exercise the hold rule.
    rAddr = OTHER_ADDR;
    rRd   = 1'b0;
    rWr   = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 2))
          0:       rAddr = IN_ADDR;
          1:       rAddr = OUT_ADDR;
          default: rAddr = OTHER_ADDR;
        endcase
        rRd = ($urandom_range(0, 1) == 1);
        rWr = ($urandom_range(0, 2) == 0);
      end
      applyStimulus(($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
                    rAddr, rRd, rWr, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
